// File: rtl/board_move_ctrl_if.sv
// Button, status and board-state signals between board_move_ctrl and its neighbours.
// master drives buttons and game_over; slave (board_move_ctrl) owns the board outputs.
interface board_move_ctrl_if;
  logic        btn_left;
  logic        btn_right;
  logic        btn_confirm;
  logic        game_over;
  logic [31:0] mem;
  logic        confirm;
  logic        invalid;
  logic [3:0]  cursor;
  logic        turn;
  logic [3:0]  move_count;

  modport master (
    output btn_left, btn_right, btn_confirm, game_over,
    input  mem, confirm, invalid, cursor, turn, move_count
  );

  modport slave (
    input  btn_left, btn_right, btn_confirm, game_over,
    output mem, confirm, invalid, cursor, turn, move_count
  );
endinterface

// File: rtl/board_move_ctrl.sv
// Move entry + packed 3x3 board memory; press-to-confirm/invalid 5 cycles (+DEBOUNCE_CYCLES
// with BOARD_DEBOUNCE_EN). No backpressure: events arriving in CHECK/WRITE are dropped.
module board_move_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input logic              clk,
  input logic              reset,
  board_move_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CHECK, WRITE, LOCKED} state_t;

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_cfg
    $error("DEBOUNCE_CYCLES must be within 2..65535");
  end

  // Button vectors are ordered {confirm, right, left}
  logic [2:0]  raw, sync1, sync2, lvl, lvl_prev, rise;
  logic        evt_confirm, evt_right, evt_left;
  state_t      state, state_nxt;
  logic        do_latch, do_write, do_invalid, do_move;
  logic [31:0] mem_q;
  logic [3:0]  cursor_q, cell_idx, move_count_q;
  logic        turn_q, confirm_q, invalid_q;
  logic [1:0]  cell_val;
  logic        cell_free;

  assign raw = {bus.btn_confirm, bus.btn_right, bus.btn_left};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

`ifdef BOARD_DEBOUNCE_EN
  for (genvar b = 0; b < 3; b++) begin : g_deb
    logic        deb;
    logic [15:0] cnt;
    // Level flips only after DEBOUNCE_CYCLES consecutive cycles of disagreement
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        deb <= 1'b0;
        cnt <= '0;
      end else if (sync2[b] == deb) begin
        cnt <= '0;
      end else if (cnt == 16'(DEBOUNCE_CYCLES - 1)) begin
        deb <= sync2[b];
        cnt <= '0;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
    assign lvl[b] = deb;
  end
`else
  assign lvl = sync2;
`endif

  assign rise = lvl & ~lvl_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lvl_prev    <= '0;
      evt_confirm <= 1'b0;
      evt_right   <= 1'b0;
      evt_left    <= 1'b0;
    end else begin
      lvl_prev    <= lvl;
      evt_confirm <= rise[2];
      evt_right   <= rise[1] & ~rise[2];
      evt_left    <= rise[0] & ~rise[1] & ~rise[2];
    end
  end

  assign cell_val  = mem_q[{cell_idx, 1'b0} +: 2];
  assign cell_free = (cell_val == 2'b00) && !bus.game_over;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (evt_confirm) state_nxt = CHECK;
      CHECK:   state_nxt = cell_free ? WRITE : IDLE;
      // move_count already holds the post-write value here
      WRITE:   state_nxt = (move_count_q == 4'd9) ? LOCKED : IDLE;
      LOCKED:  state_nxt = LOCKED;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    do_latch   = 1'b0;
    do_write   = 1'b0;
    do_invalid = 1'b0;
    do_move    = 1'b0;
    case (state)
      IDLE: begin
        do_latch = evt_confirm;
        do_move  = 1'b1;
      end
      CHECK: begin
        do_write   = cell_free;
        do_invalid = !cell_free;
      end
      LOCKED: begin
        do_invalid = evt_confirm;
        do_move    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q        <= '0;
      cursor_q     <= '0;
      cell_idx     <= '0;
      move_count_q <= '0;
      turn_q       <= 1'b0;
      confirm_q    <= 1'b0;
      invalid_q    <= 1'b0;
    end else begin
      confirm_q <= do_write;
      invalid_q <= do_invalid;
      if (do_latch) cell_idx <= cursor_q;
      if (do_write) begin
        mem_q[{cell_idx, 1'b0} +: 2] <= {1'b1, turn_q};
        turn_q                       <= ~turn_q;
        move_count_q                 <= move_count_q + 4'd1;
      end
      if (do_move && evt_right)
        cursor_q <= (cursor_q == 4'd8) ? 4'd0 : cursor_q + 4'd1;
      else if (do_move && evt_left)
        cursor_q <= (cursor_q == 4'd0) ? 4'd8 : cursor_q - 4'd1;
    end
  end

  assign bus.mem        = mem_q;
  assign bus.cursor     = cursor_q;
  assign bus.move_count = move_count_q;
  assign bus.turn       = turn_q;
  assign bus.confirm    = confirm_q;
  assign bus.invalid    = invalid_q;

endmodule

// File: tb/tb_board_move_ctrl.sv
// Scoreboard bench for board_move_ctrl: each press pushes its expected confirm/invalid outcome.
module tb_board_move_ctrl;
  localparam int DB = 16;
`ifdef BOARD_DEBOUNCE_EN
  localparam int LAT_EXTRA = DB;
  localparam int HOLD      = 20;
  localparam int GAP       = 30;
`else
  localparam int LAT_EXTRA = 0;
  localparam int HOLD      = 3;
  localparam int GAP       = 8;
`endif

  typedef struct {
    bit          is_confirm;
    logic [31:0] mem;
    logic        turn;
    logic [3:0]  cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  board_move_ctrl_if bus();

  board_move_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_confirm = 0;
  logic [31:0] m_mem;
  logic        m_turn;
  int          m_cnt;
  int          m_cursor;
  bit          m_locked;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && (bus.confirm || bus.invalid)) begin
      if (bus.confirm) n_confirm++;
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_pulse: confirm=%0b invalid=%0b, required no pulse", bus.confirm, bus.invalid);
      end else begin
        e = sb.pop_front();
        if ({bus.confirm, bus.invalid, bus.mem, bus.turn, bus.move_count} !==
            {e.is_confirm, !e.is_confirm, e.mem, e.turn, e.cnt})
          $display("FAIL pulse_result: got c=%0b i=%0b mem=%h turn=%0b cnt=%0d, want c=%0b i=%0b mem=%h turn=%0b cnt=%0d",
                   bus.confirm, bus.invalid, bus.mem, bus.turn, bus.move_count,
                   e.is_confirm, !e.is_confirm, e.mem, e.turn, e.cnt);
        else n_pass++;
      end
    end
  end

  task automatic model_reset();
    m_mem = '0; m_turn = 1'b0; m_cnt = 0; m_cursor = 0; m_locked = 1'b0;
    sb.delete();
    n_confirm = 0;
  endtask

  // m = {confirm, right, left}
  task automatic model_step(input logic [2:0] m);
    exp_t e;
    if (m[2]) begin
      e.is_confirm = 1'b0;
      if (!m_locked && m_mem[2*m_cursor +: 2] == 2'b00 && !bus.game_over) begin
        m_mem[2*m_cursor +: 2] = m_turn ? 2'b11 : 2'b10;
        m_turn = !m_turn;
        m_cnt++;
        if (m_cnt == 9) m_locked = 1'b1;
        e.is_confirm = 1'b1;
      end
      e.mem = m_mem; e.turn = m_turn; e.cnt = 4'(m_cnt);
      sb.push_back(e);
    end else if (m[1]) m_cursor = (m_cursor == 8) ? 0 : m_cursor + 1;
    else if (m[0])     m_cursor = (m_cursor == 0) ? 8 : m_cursor - 1;
  endtask

  task automatic press(input logic [2:0] m);
    model_step(m);
    @(negedge clk);
    {bus.btn_confirm, bus.btn_right, bus.btn_left} = m;
    repeat (HOLD) @(negedge clk);
    {bus.btn_confirm, bus.btn_right, bus.btn_left} = 3'b000;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    {bus.btn_confirm, bus.btn_right, bus.btn_left} = 3'b000;
    bus.game_over = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    {bus.btn_confirm, bus.btn_right, bus.btn_left} = 3'b000;
    bus.game_over = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.mem, bus.confirm, bus.invalid, bus.cursor, bus.turn, bus.move_count} !== 43'd0)
      $display("FAIL reset_state: mem=%h c=%0b i=%0b cur=%0d turn=%0b cnt=%0d, want all 0",
               bus.mem, bus.confirm, bus.invalid, bus.cursor, bus.turn, bus.move_count);
    else n_pass++;
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_cursor();
    repeat (4) press(3'b010);
    n_checks++;
    if (bus.cursor !== 4'd4) $display("FAIL cursor_right4: got %0d want 4", bus.cursor);
    else n_pass++;
    repeat (5) press(3'b001);
    n_checks++;
    if (bus.cursor !== 4'd8) $display("FAIL cursor_left5_wrap: got %0d want 8", bus.cursor);
    else n_pass++;
    press(3'b010);
    n_checks++;
    if (bus.cursor !== 4'(m_cursor)) $display("FAIL cursor_right_wrap: got %0d want %0d", bus.cursor, m_cursor);
    else n_pass++;
  endtask

  task automatic test_first_moves();
    apply_reset();
    press(3'b100);
    n_checks++;
    if ({bus.mem, bus.turn, bus.move_count} !== {32'h0000_0002, 1'b1, 4'd1})
      $display("FAIL first_move: mem=%h turn=%0b cnt=%0d, want 00000002/1/1", bus.mem, bus.turn, bus.move_count);
    else n_pass++;
    press(3'b010);
    press(3'b100);
    n_checks++;
    if ({bus.mem, bus.turn, bus.move_count} !== {32'h0000_000E, 1'b0, 4'd2})
      $display("FAIL second_move: mem=%h turn=%0b cnt=%0d, want 0000000e/0/2", bus.mem, bus.turn, bus.move_count);
    else n_pass++;
  endtask

  task automatic test_invalid();
    press(3'b100);
    n_checks++;
    if ({bus.mem, bus.turn, bus.move_count} !== {32'h0000_000E, 1'b0, 4'd2})
      $display("FAIL occupied_unchanged: mem=%h turn=%0b cnt=%0d, want 0000000e/0/2", bus.mem, bus.turn, bus.move_count);
    else n_pass++;
    press(3'b010);
    bus.game_over = 1'b1;
    press(3'b100);
    bus.game_over = 1'b0;
    n_checks++;
    if ({bus.mem, bus.turn, bus.move_count} !== {32'h0000_000E, 1'b0, 4'd2})
      $display("FAIL game_over_unchanged: mem=%h turn=%0b cnt=%0d, want 0000000e/0/2", bus.mem, bus.turn, bus.move_count);
    else n_pass++;
    n_checks++;
    if (sb.size() !== 0) $display("FAIL invalid_pulses_seen: %0d outstanding, want 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_same_cycle();
    press(3'b110);
    n_checks++;
    if ({bus.mem, bus.cursor, bus.move_count} !== {32'h0000_002E, 4'd2, 4'd3})
      $display("FAIL confirm_beats_right: mem=%h cur=%0d cnt=%0d, want 0000002e/2/3", bus.mem, bus.cursor, bus.move_count);
    else n_pass++;
  endtask

  task automatic test_reset_in_check();
    press(3'b010);
    @(negedge clk);
    bus.btn_confirm = 1'b1;
    repeat (4 + LAT_EXTRA) @(posedge clk);
    #1;
    reset = 1'b1;
    bus.btn_confirm = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({bus.mem, bus.confirm, bus.invalid, bus.cursor, bus.turn, bus.move_count} !== 43'd0)
      $display("FAIL reset_in_check: mem=%h c=%0b i=%0b cur=%0d turn=%0b cnt=%0d, want all 0",
               bus.mem, bus.confirm, bus.invalid, bus.cursor, bus.turn, bus.move_count);
    else n_pass++;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (GAP) @(negedge clk);
    n_checks++;
    if ({bus.mem, 4'(n_confirm)} !== 36'd0)
      $display("FAIL reset_abort_no_write: mem=%h confirms=%0d, want 0/0", bus.mem, n_confirm);
    else n_pass++;
  endtask

  task automatic test_fill_board();
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      press(3'b100);
      if (i < 8) press(3'b010);
    end
    n_checks++;
    if ({bus.mem, bus.move_count, 4'(n_confirm)} !== {32'h0002_EEEE, 4'd9, 4'd9})
      $display("FAIL full_board: mem=%h cnt=%0d confirms=%0d, want 0002eeee/9/9", bus.mem, bus.move_count, n_confirm);
    else n_pass++;
    press(3'b100);
    press(3'b010);
    n_checks++;
    if ({bus.cursor, bus.move_count, 4'(n_confirm)} !== {4'd0, 4'd9, 4'd9})
      $display("FAIL locked_behaviour: cur=%0d cnt=%0d confirms=%0d, want 0/9/9", bus.cursor, bus.move_count, n_confirm);
    else n_pass++;
    n_checks++;
    if (sb.size() !== 0) $display("FAIL locked_invalid_seen: %0d outstanding, want 0", sb.size());
    else n_pass++;
  endtask

`ifdef BOARD_DEBOUNCE_EN
  task automatic test_debounce();
    apply_reset();
    @(negedge clk);
    bus.btn_confirm = 1'b1;
    repeat (10) @(negedge clk);
    bus.btn_confirm = 1'b0;
    repeat (GAP + 10) @(negedge clk);
    n_checks++;
    if (n_confirm !== 0) $display("FAIL glitch_rejected: confirms=%0d want 0", n_confirm);
    else n_pass++;
    press(3'b100);
    n_checks++;
    if ({4'(n_confirm), bus.mem} !== {4'd1, 32'h0000_0002})
      $display("FAIL debounced_press: confirms=%0d mem=%h want 1/00000002", n_confirm, bus.mem);
    else n_pass++;
  endtask
`endif

  initial begin
    bus.btn_left = 1'b0; bus.btn_right = 1'b0; bus.btn_confirm = 1'b0; bus.game_over = 1'b0;
    test_reset();
    test_cursor();
    test_first_moves();
    test_invalid();
    test_same_cycle();
    test_reset_in_check();
    test_fill_board();
`ifdef BOARD_DEBOUNCE_EN
    test_debounce();
`endif
    n_checks++;
    if (sb.size() !== 0) $display("FAIL scoreboard_drained: %0d outstanding, want 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/board_move_ctrl.md
# board_move_ctrl

Upstream move-entry and board-memory stage for the tic-tac-toe datapath. Turns player button presses into validated moves on a 3×3 board. Owns the packed 32-bit board memory and emits a one-cycle `confirm` pulse for every accepted move. The board memory and `confirm` feed the win/turn status checker directly; that checker's `game_over` indication returns to this block to lock the board.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: stable-level cycles required before a button press is accepted. Used only with `BOARD_DEBOUNCE_EN`. Legal range 2..65535.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  reset, asynchronous, active-high; clock clk
- `btn_left`  in  1  raw async button, move cursor to previous cell
- `btn_right`  in  1  raw async button, move cursor to next cell
- `btn_confirm`  in  1  raw async button, place mark at cursor
- `game_over`  in  1  from status checker, high when a win or draw is decided
- `mem`  out  32  board: cell i at `mem[2i+1:2i]`, i=0..8; `mem[31:18]` always 0
- `confirm`  out  1  one-cycle pulse per accepted move
- `invalid`  out  1  one-cycle pulse per rejected confirm press
- `cursor`  out  4  selected cell, 0..8
- `turn`  out  1  0 = player 1 to move, 1 = player 2 to move
- `move_count`  out  4  accepted moves since reset, 0..9

## Operation
- Cell encoding: 2'b00 empty, 2'b10 player 1, 2'b11 player 2. Code 2'b01 is never written.
- Each button input passes through a 2-flop synchronizer followed by rising-edge detection. Each press yields exactly one event. Holding a button does not repeat.
- Same-cycle events are prioritised confirm > right > left. Lower-priority events in that cycle are dropped.
- Cursor: right steps 8→0 with wrap; left steps 0→8 with wrap. Cursor moves are accepted in IDLE and LOCKED; in CHECK and WRITE they are dropped.
- FSM states: IDLE, CHECK, WRITE, LOCKED.
  - IDLE + confirm event → CHECK; the cursor value is latched.
  - CHECK → WRITE if the latched cell is 00 and `game_over`=0. Otherwise pulse `invalid` and return to IDLE.
  - WRITE: write 2'b10 if `turn`=0, else 2'b11. Pulse `confirm`, toggle `turn`, and increment `move_count`. Next state is LOCKED if the new `move_count`=9, else IDLE.
  - LOCKED: every confirm event pulses `invalid`. The block exits LOCKED only on reset.
- `game_over` is sampled only in CHECK. It does not force a state change on its own.
- `confirm` and `invalid` are never high in the same cycle.
- `move_count` never exceeds 9, and `confirm` never pulses more than 9 times between resets.

## Timing
- Reset values: `mem`=0, `cursor`=0, `turn`=0, `move_count`=0, `confirm`=0, `invalid`=0, state IDLE, all synchronizer and debounce flops 0.
- Reset is asynchronous. Asserting it mid-move (CHECK or WRITE) aborts the move with no partial write and no `confirm`.
- Without `BOARD_DEBOUNCE_EN`: let raw input first be sampled high at edge k.
  - Edge event at k+2.
  - Cursor update visible after k+3.
  - Confirm: CHECK at k+3; `confirm` or `invalid` high for the cycle after edge k+4; `mem` updated after edge k+4.
- Acceptance rate: at most one move per 3 cycles. A confirm event arriving in CHECK or WRITE is dropped.
- All outputs are registered. No combinational path exists from inputs to outputs.

## Configuration
- `BOARD_DEBOUNCE_EN` defined:
  - Each synchronized button feeds a counter.
  - The debounced level changes only after the synchronized level has differed from it for `DEBOUNCE_CYCLES` consecutive cycles. The edge event is taken from the debounced level.
  - Total latency increases by `DEBOUNCE_CYCLES`.
  - Glitches shorter than `DEBOUNCE_CYCLES` produce no event.
- `BOARD_DEBOUNCE_EN` undefined: no counters are instantiated; the edge event is taken from the synchronized level. Intended for simulation and for boards with external debouncing.

## Test plan
- Reset → press right 4× → `cursor`=4; press left 5× → `cursor`=8.
- From reset, confirm at cursor 0 → `mem`=32'h0000_0002, `confirm` pulses once, `turn`=1, `move_count`=1. Right, then confirm → `mem`=32'h0000_000E, `turn`=0.
- Confirm on an occupied cell, and confirm with `game_over`=1 → each gives one `invalid` pulse with no `confirm`; `mem`, `turn` and `move_count` unchanged.
- Fill all 9 cells alternately with `game_over`=0 → `move_count`=9, state LOCKED, exactly 9 `confirm` pulses; a further confirm gives `invalid` only.
- Confirm and right pressed in the same cycle → move placed at the old cursor and cursor unchanged. Reset asserted while in CHECK → all outputs return to reset values with no `confirm`.
- With `BOARD_DEBOUNCE_EN` and `DEBOUNCE_CYCLES`=16: a 10-cycle confirm glitch produces no event; a 20-cycle press produces exactly one `confirm`.
